// File: rtl/uart_rx_buffered_pkg.sv
// Shared UART receive definitions: deframer states and bit-timing helpers.
// Timing helpers are constant functions so they can size counters at elaboration.
package uart_rx_buffered_pkg;

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   function automatic int sample_time(input int clock_freq, input int baud_rate);
      return symbol_edge_time(clock_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// First-word-fall-through FIFO; head is visible the cycle after its push.
// Push when full is dropped unless a pop happens in the same cycle.
module uart_rx_buffered_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   // A pop on a full FIFO frees the slot being written this same cycle.
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a synchronizer, deframer and FWFT byte buffer; stop bit sampled ~9.5 bit times after the fall.
// Consumer backpressure via data_out_ready; a byte completing into a full buffer is dropped with an overrun pulse.
module uart_rx_buffered
   import uart_rx_buffered_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DEPTH      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_err,
   output logic       overrun
);

   localparam int SYM    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
   localparam int SAMPLE = sample_time(CLOCK_FREQ, BAUD_RATE);
   localparam int CNT_W  = $clog2(SYM);
   localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYM - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE - 1);

   logic [1:0]       sync;
   logic             rx;
   rx_state_t        state;
   rx_state_t        state_n;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             cnt_clr;
   logic             shift_en;
   logic             push;
   logic             ferr;
   logic             full;
   logic             empty;
   logic             pop;

   assign rx             = sync[1];
   assign data_out_valid = ~empty;
   assign pop            = data_out_valid & data_out_ready;

   always_comb begin
      state_n  = state;
      cnt_clr  = 1'b0;
      shift_en = 1'b0;
      push     = 1'b0;
      ferr     = 1'b0;
      case (state)
         WAIT_HIGH: begin
            cnt_clr = 1'b1;
            if (rx) state_n = IDLE;
         end
         IDLE: begin
            cnt_clr = 1'b1;
            if (!rx) state_n = START;
         end
         START: if (cnt == SAMPLE_LAST) begin
            cnt_clr = 1'b1;
            state_n = rx ? IDLE : DATA;
         end
         DATA: if (cnt == SYM_LAST) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
            if (bit_idx == 3'd7) state_n = STOP;
         end
         STOP: if (cnt == SYM_LAST) begin
            cnt_clr = 1'b1;
            if (rx) begin
               push    = 1'b1;
               state_n = IDLE;
            end else begin
               ferr    = 1'b1;
               state_n = WAIT_HIGH;
            end
         end
         default: state_n = WAIT_HIGH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WAIT_HIGH;
         sync        <= 2'b11;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_n;
         sync        <= {sync[0], serial_in};
         cnt         <= cnt_clr ? '0 : cnt + CNT_W'(1);
         if (shift_en) begin
            shreg   <= {rx, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end else if (state != DATA) begin
            bit_idx <= '0;
         end
         framing_err <= ferr;
         overrun     <= push & full & ~pop;
      end
   end

   uart_rx_buffered_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shreg),
      .pop       (data_out_ready),
      .pop_data  (data_out),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench: serial frames are driven bit by bit, expected bytes queued per frame rules, a monitor checks pops.
module tb_uart_rx_buffered;

   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD   = 2_000_000;
   localparam int DEPTH  = 8;
   localparam int SYM    = CLK_HZ / BAUD;
   localparam int SAMPLE = SYM / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       framing_err;
   logic       overrun;

   int vectors = 0;
   int miscompares = 0;
   int fe_seen = 0;
   int fe_exp = 0;
   int ov_seen = 0;
   int ov_exp = 0;
   int lat;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_buffered #(
      .CLOCK_FREQ (CLK_HZ),
      .BAUD_RATE  (BAUD),
      .DEPTH      (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .serial_in      (serial_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .framing_err    (framing_err),
      .overrun        (overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // One 8N1 frame, exactly 10*SYM cycles; line left idle-high afterwards.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      serial_in = 1'b0;
      repeat (SYM) tick();
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         repeat (SYM) tick();
      end
      serial_in = stop_ok;
      repeat (SYM) tick();
      serial_in = 1'b1;
   endtask

   task automatic drain(input int limit, input string tag);
      for (int k = 0; k < limit && exp_q.size() != 0; k++) tick();
      chk({tag, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_framing_count"}, fe_seen, fe_exp);
      chk({tag, "_overrun_count"}, ov_seen, ov_exp);
   endtask

   initial begin
      #500_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      bit         bad;
      int         gap;

      rst = 1'b1;
      serial_in = 1'b1;
      data_out_ready = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (data_out_valid && data_out_ready) begin
                  if (exp_q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("FAIL unexpected_byte: actual 0x%02h required no byte", data_out);
                  end else begin
                     chk("data_out", int'(data_out), int'(exp_q.pop_front()));
                  end
               end
               if (framing_err) fe_seen++;
               if (overrun) ov_seen++;
               if (framing_err && overrun) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL err_exclusive: actual both pulses required at most one");
               end
            end
         end
      join_none

      repeat (5) tick();
      rst = 1'b0;
      tick();
      chk("reset_valid", int'(data_out_valid), 0);
      chk("reset_framing_err", int'(framing_err), 0);
      chk("reset_overrun", int'(overrun), 0);

      // Single frame: latency and one-cycle presentation with ready held.
      data_out_ready = 1'b1;
      exp_q.push_back(8'hA5);
      fork
         send_byte(8'hA5, 1'b1);
         begin
            lat = 0;
            while (!data_out_valid && lat < 12 * SYM) begin
               tick();
               lat++;
            end
            chk_range("t1_latency", lat, 9 * SYM + SAMPLE, 9 * SYM + SAMPLE + 4);
            tick();
            chk("t1_single_cycle", int'(data_out_valid), 0);
         end
      join
      drain(4 * SYM, "t1");
      check_flags("t1");

      // Short low glitch must not start a frame.
      serial_in = 1'b0;
      repeat (SAMPLE / 2) tick();
      serial_in = 1'b1;
      repeat (2 * SYM) tick();
      chk("t2_glitch_no_valid", int'(data_out_valid), 0);
      check_flags("t2_glitch");
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1);
      drain(4 * SYM, "t2");
      check_flags("t2");

      // Bad stop bit discards the byte, next frame still received.
      fe_exp++;
      send_byte(8'h3C, 1'b0);
      repeat (SYM) tick();
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1);
      drain(4 * SYM, "t3");
      check_flags("t3");

      // Nine frames into an unread buffer: ninth overruns.
      data_out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         b = 8'(i);
         if (i < DEPTH) exp_q.push_back(b);
         send_byte(b, 1'b1);
      end
      ov_exp++;
      repeat (SYM) tick();
      chk("t4_full_valid", int'(data_out_valid), 1);
      data_out_ready = 1'b1;
      drain(4 * DEPTH, "t4");
      repeat (2) tick();
      chk("t4_empty_after", int'(data_out_valid), 0);
      check_flags("t4");

      // Full buffer with a pop landing on the ninth push edge.
      data_out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'h10 + 8'(i);
         exp_q.push_back(b);
         send_byte(b, 1'b1);
      end
      exp_q.push_back(8'h18);
      fork
         send_byte(8'h18, 1'b1);
         begin
            repeat (9 * SYM + SAMPLE + 2) tick();
            data_out_ready = 1'b1;
         end
      join
      drain(4 * DEPTH + SYM, "t5");
      check_flags("t5");

      // Reset mid-frame with the line still low.
      serial_in = 1'b0;
      repeat (SYM + SYM / 2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_reset_valid", int'(data_out_valid), 0);
      repeat (SYM / 2) tick();
      serial_in = 1'b1;
      repeat (2 * SYM) tick();
      chk("t6_no_valid", int'(data_out_valid), 0);
      check_flags("t6_abort");
      exp_q.push_back(8'hC3);
      send_byte(8'hC3, 1'b1);
      drain(4 * SYM, "t6");
      check_flags("t6");

      // Random bytes, occasional bad stop bits, random consumer stalls.
      for (int n = 0; n < 40; n++) begin
         b = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 7) == 0);
         if (bad) fe_exp++;
         else exp_q.push_back(b);
         fork
            send_byte(b, !bad);
            begin
               repeat (10 * SYM) begin
                  tick();
                  data_out_ready = 1'($urandom_range(0, 1));
               end
            end
         join
         gap = $urandom_range(0, SYM) + (bad ? SYM : 0);
         repeat (gap) begin
            tick();
            data_out_ready = 1'($urandom_range(0, 1));
         end
      end
      data_out_ready = 1'b1;
      drain(4 * DEPTH + SYM, "rand");
      repeat (2) tick();
      check_flags("rand");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
